// File: rtl/sp_mem_pkg.sv
// Shared types and constants for the single-port memory front-end.
// Grant encoding and the minimum response-buffer depth.
package sp_mem_pkg;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_WRITE,
    GRANT_READ
  } grant_t;

  localparam int unsigned RESP_DEPTH_MIN = 2;

endpackage

// File: rtl/sp_mem_resp_fifo.sv
// Register-based response FIFO with an exported occupancy count.
// Overflow is impossible under the arbiter's credit rule and is asserted against.
module sp_mem_resp_fifo
  import sp_mem_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned RESP_DEPTH = RESP_DEPTH_MIN,
  localparam int unsigned CntW      = $clog2(RESP_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 push_i,
  input  logic [DATAWIDTH-1:0] data_i,
  input  logic                 pop_i,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 valid_o,
  output logic [CntW-1:0]      count_o
);

  localparam int unsigned PtrW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [DATAWIDTH-1:0] entries_q [RESP_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign valid_o = (count_q != '0);
  assign data_o  = entries_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        entries_q[wr_ptr_q] <= data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(push_i && !do_pop && (count_q == CntW'(RESP_DEPTH))));
    end
  end

endmodule

// File: rtl/sp_mem_arbiter.sv
// Round-robin write/read arbiter in front of a single-port memory with 1-cycle
// registered-address read latency; read data returns through a small response FIFO.
module sp_mem_arbiter
  import sp_mem_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = 8,
  parameter int unsigned DATADEPTH    = 1024,
  parameter int unsigned ADDRESSWIDTH = $clog2(DATADEPTH),
  parameter int unsigned RESP_DEPTH   = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [ADDRESSWIDTH-1:0] wr_address_i,
  input  logic [DATAWIDTH-1:0]    wr_data_i,
  input  logic                    rd_req_valid_i,
  output logic                    rd_req_ready_o,
  input  logic [ADDRESSWIDTH-1:0] rd_address_i,
  output logic                    rd_resp_valid_o,
  input  logic                    rd_resp_ready_i,
  output logic [DATAWIDTH-1:0]    rd_resp_data_o,
  output logic                    mem_write_en_o,
  output logic [DATAWIDTH-1:0]    mem_data_in_o,
  output logic [ADDRESSWIDTH-1:0] mem_address_o,
  input  logic [DATAWIDTH-1:0]    mem_data_out_i
);

  localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);

  if (RESP_DEPTH < RESP_DEPTH_MIN) begin : gen_depth_check
    $error("sp_mem_arbiter: RESP_DEPTH must be at least RESP_DEPTH_MIN");
  end

  grant_t                  grant;
  logic                    inflight_q, inflight_d;
  logic                    prefer_write_q, prefer_write_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [CntW-1:0]         resp_count;
  logic [CntW:0]           credits_used;
  logic                    pop;
  logic                    rd_eligible;

  assign pop = rd_resp_valid_o & rd_resp_ready_i;

  // Slots committed once this cycle's pop retires: buffered plus the read in the memory pipe.
  assign credits_used = (CntW + 1)'(resp_count) + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
  assign rd_eligible  = rd_req_valid_i && (credits_used < (CntW + 1)'(RESP_DEPTH));

  always_comb begin
    grant = GRANT_NONE;
    if (!reset_i) begin
      if (wr_valid_i && rd_eligible) begin
        grant = prefer_write_q ? GRANT_WRITE : GRANT_READ;
      end else if (wr_valid_i) begin
        grant = GRANT_WRITE;
      end else if (rd_eligible) begin
        grant = GRANT_READ;
      end
    end
  end

  always_comb begin
    wr_ready_o     = (grant == GRANT_WRITE);
    rd_req_ready_o = (grant == GRANT_READ);
    mem_write_en_o = (grant == GRANT_WRITE);
    mem_data_in_o  = wr_data_i;
    unique case (grant)
      GRANT_WRITE: mem_address_o = wr_address_i;
      GRANT_READ:  mem_address_o = rd_address_i;
      default:     mem_address_o = addr_q;
    endcase
  end

  always_comb begin
    inflight_d     = (grant == GRANT_READ);
    addr_d         = mem_address_o;
    prefer_write_d = prefer_write_q;
    if (grant == GRANT_WRITE) begin
      prefer_write_d = 1'b0;
    end else if (grant == GRANT_READ) begin
      prefer_write_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inflight_q     <= 1'b0;
      prefer_write_q <= 1'b1;
      addr_q         <= '0;
    end else begin
      inflight_q     <= inflight_d;
      prefer_write_q <= prefer_write_d;
      addr_q         <= addr_d;
    end
  end

  // The memory's data_out reflects the address registered at the previous edge.
  sp_mem_resp_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .RESP_DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (inflight_q),
    .data_i (mem_data_out_i),
    .pop_i  (pop),
    .data_o (rd_resp_data_o),
    .valid_o(rd_resp_valid_o),
    .count_o(resp_count)
  );

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Directed bench for sp_mem_arbiter with a behavioural single-port memory
// (registered address, combinational data_out, write at the clock edge).
module tb_sp_mem_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned DD = 1024;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_address;
  logic          rd_resp_valid, rd_resp_ready;
  logic [DW-1:0] rd_resp_data;
  logic          mem_write_en;
  logic [DW-1:0] mem_data_in;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out;

  logic [DW-1:0] mem [DD];
  logic [AW-1:0] mem_addr_q;
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write_en) mem[mem_address] <= mem_data_in;
    mem_addr_q <= mem_address;
  end
  assign mem_data_out = mem[mem_addr_q];

  sp_mem_arbiter #(
    .DATAWIDTH (DW),
    .DATADEPTH (DD),
    .RESP_DEPTH(2)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_address_i   (wr_address),
    .wr_data_i      (wr_data),
    .rd_req_valid_i (rd_req_valid),
    .rd_req_ready_o (rd_req_ready),
    .rd_address_i   (rd_address),
    .rd_resp_valid_o(rd_resp_valid),
    .rd_resp_ready_i(rd_resp_ready),
    .rd_resp_data_o (rd_resp_data),
    .mem_write_en_o (mem_write_en),
    .mem_data_in_o  (mem_data_in),
    .mem_address_o  (mem_address),
    .mem_data_out_i (mem_data_out)
  );

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; wr_valid = 1'b0; rd_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    preload(10'd100, 8'h00);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset = 1'b1; wr_valid = 1'b1; wr_address = 10'd100; wr_data = 8'hEE;
      rd_req_valid = 1'b1; rd_address = 10'd1; rd_resp_ready = 1'b1;
      #1;
      n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
      n_tests++; if (rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req_ready: got %b want 0", rd_req_ready); end
      n_tests++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write_en: got %b want 0", mem_write_en); end
    end
    @(negedge clk);
    reset = 1'b0; wr_valid = 1'b0; rd_req_valid = 1'b0;
    #1;
    n_tests++; if (rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_resp_valid: got %b want 0", rd_resp_valid); end
    n_tests++; if (mem[100] !== 8'h00) begin n_fail++; $display("FAIL reset_no_write: got %h want 00", mem[100]); end
  endtask

  task automatic test_write_read();
    rd_resp_ready = 1'b1;
    @(negedge clk);
    wr_valid = 1'b1; wr_address = 10'd3; wr_data = 8'hA5;
    #1;
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_grant: got %b want 1", wr_ready); end
    n_tests++; if (mem_write_en !== 1'b1) begin n_fail++; $display("FAIL wr_mem_we: got %b want 1", mem_write_en); end
    n_tests++; if (mem_address !== 10'd3) begin n_fail++; $display("FAIL wr_mem_addr: got %0d want 3", mem_address); end
    n_tests++; if (mem_data_in !== 8'hA5) begin n_fail++; $display("FAIL wr_mem_data: got %h want a5", mem_data_in); end
    @(negedge clk);
    wr_valid = 1'b0; rd_req_valid = 1'b1; rd_address = 10'd3;
    #1;
    n_tests++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_grant: got %b want 1", rd_req_ready); end
    n_tests++; if (mem_write_en !== 1'b0 || mem_address !== 10'd3) begin n_fail++; $display("FAIL rd_mem_pins: got we=%b addr=%0d want we=0 addr=3", mem_write_en, mem_address); end
    @(negedge clk);
    rd_req_valid = 1'b0;
    #1;
    n_tests++; if (rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency_early: got %b want 0", rd_resp_valid); end
    @(negedge clk);
    #1;
    n_tests++; if (rd_resp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_latency_2: got %b want 1", rd_resp_valid); end
    n_tests++; if (rd_resp_data !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h want a5", rd_resp_data); end
    @(negedge clk);
    #1;
    n_tests++; if (rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_popped: got %b want 0", rd_resp_valid); end
  endtask

  task automatic test_alternate();
    int resp_n;
    resp_n = 0;
    preload(10'd21, 8'h77);
    do_reset();
    rd_resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr_valid = (i < 6); wr_address = 10'd20; wr_data = 8'h5A;
      rd_req_valid = (i < 6); rd_address = 10'd21;
      #1;
      if (i < 6) begin
        n_tests++;
        if ({wr_ready, rd_req_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL alt_grant cycle %0d: got %b want %b", i,
                             {wr_ready, rd_req_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      if (rd_resp_valid) begin
        resp_n++;
        n_tests++; if (rd_resp_data !== 8'h77) begin n_fail++; $display("FAIL alt_resp_data: got %h want 77", rd_resp_data); end
      end
    end
    n_tests++; if (resp_n !== 3) begin n_fail++; $display("FAIL alt_resp_count: got %0d want 3", resp_n); end
    n_tests++; if (mem[20] !== 8'h5A) begin n_fail++; $display("FAIL alt_write: got %h want 5a", mem[20]); end
  endtask

  task automatic test_back_to_back();
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) preload(AW'(i), DW'(8'h10 + i));
    rd_resp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rd_req_valid = (i < 8); rd_address = AW'(i);
      #1;
      if (i < 8) begin
        n_tests++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cycle %0d: got %b want 1", i, rd_req_ready); end
      end
      if (rd_resp_valid) begin
        n_tests++; if (rd_resp_data !== DW'(8'h10 + k)) begin n_fail++; $display("FAIL b2b_data %0d: got %h want %h", k, rd_resp_data, DW'(8'h10 + k)); end
        n_tests++; if (i !== k + 2) begin n_fail++; $display("FAIL b2b_timing %0d: got cycle %0d want %0d", k, i, k + 2); end
        k++;
      end
    end
    n_tests++; if (k !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", k); end
  endtask

  task automatic test_backpressure();
    int acc, k;
    acc = 0; k = 0;
    for (int i = 0; i < 6; i++) preload(AW'(40 + i), DW'(8'h80 + i));
    rd_resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rd_req_valid = 1'b1; rd_address = AW'(40 + acc);
      #1;
      if (c >= 2) begin
        n_tests++; if (rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall cycle %0d: got %b want 0", c, rd_req_ready); end
      end
      if (rd_req_ready) acc++;
    end
    n_tests++; if (acc !== 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", acc); end
    n_tests++; if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'h80) begin n_fail++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=80", rd_resp_valid, rd_resp_data); end
    for (int c = 0; c < 20 && k < 6; c++) begin
      @(negedge clk);
      rd_resp_ready = 1'b1; rd_req_valid = (acc < 6); rd_address = AW'(40 + acc);
      #1;
      if (rd_resp_valid) begin
        n_tests++; if (rd_resp_data !== DW'(8'h80 + k)) begin n_fail++; $display("FAIL bp_data %0d: got %h want %h", k, rd_resp_data, DW'(8'h80 + k)); end
        k++;
      end
      if (rd_req_valid && rd_req_ready) acc++;
    end
    n_tests++; if (k !== 6 || acc !== 6) begin n_fail++; $display("FAIL bp_drain: got resp=%0d acc=%0d want 6/6", k, acc); end
    @(negedge clk);
    rd_req_valid = 1'b0;
    #1;
    n_tests++; if (rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", rd_resp_valid); end
  endtask

  task automatic test_read_then_write();
    preload(10'd5, 8'h33);
    rd_resp_ready = 1'b1;
    @(negedge clk);
    rd_req_valid = 1'b1; rd_address = 10'd5;
    #1;
    n_tests++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_rd_grant: got %b want 1", rd_req_ready); end
    @(negedge clk);
    rd_req_valid = 1'b0; wr_valid = 1'b1; wr_address = 10'd5; wr_data = 8'h44;
    #1;
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rw_wr_grant: got %b want 1", wr_ready); end
    @(negedge clk);
    wr_valid = 1'b0; rd_req_valid = 1'b1; rd_address = 10'd5;
    #1;
    n_tests++; if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'h33) begin n_fail++; $display("FAIL rw_old_data: got v=%b d=%h want v=1 d=33", rd_resp_valid, rd_resp_data); end
    n_tests++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_rd2_grant: got %b want 1", rd_req_ready); end
    @(negedge clk);
    rd_req_valid = 1'b0;
    @(negedge clk);
    #1;
    n_tests++; if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'h44) begin n_fail++; $display("FAIL rw_new_data: got v=%b d=%h want v=1 d=44", rd_resp_valid, rd_resp_data); end
  endtask

  task automatic test_reset_mid();
    preload(10'd9, 8'h99);
    preload(10'd13, 8'h00);
    rd_resp_ready = 1'b0;
    // Reset one cycle after a read grant: the in-flight read must vanish.
    @(negedge clk);
    rd_req_valid = 1'b1; rd_address = 10'd9;
    #1;
    n_tests++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_rd_grant: got %b want 1", rd_req_ready); end
    @(negedge clk);
    rd_req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++; if (rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_inflight_dropped cycle %0d: got %b want 0", c, rd_resp_valid); end
      @(negedge clk);
    end
    // Buffered response plus prefer_write=0 going into reset.
    rd_req_valid = 1'b1; rd_address = 10'd9;
    #1;
    n_tests++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_rd2_grant: got %b want 1", rd_req_ready); end
    @(negedge clk);
    rd_req_valid = 1'b0; wr_valid = 1'b1; wr_address = 10'd12; wr_data = 8'h66;
    #1;
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rm_wr_grant: got %b want 1", wr_ready); end
    @(negedge clk);
    reset = 1'b1; wr_address = 10'd13; wr_data = 8'h77;
    #1;
    n_tests++; if (mem_write_en !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL rm_no_write_in_reset: got we=%b rdy=%b want 0/0", mem_write_en, wr_ready); end
    @(negedge clk);
    reset = 1'b0; rd_resp_ready = 1'b1;
    wr_valid = 1'b1; wr_address = 10'd14; wr_data = 8'h55;
    rd_req_valid = 1'b1; rd_address = 10'd9;
    #1;
    n_tests++; if (rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_buffer_flushed: got %b want 0", rd_resp_valid); end
    n_tests++; if ({wr_ready, rd_req_ready} !== 2'b10) begin n_fail++; $display("FAIL rm_prefer_write: got %b want 10", {wr_ready, rd_req_ready}); end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    n_tests++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_fresh_grant: got %b want 1", rd_req_ready); end
    @(negedge clk);
    rd_req_valid = 1'b0;
    @(negedge clk);
    #1;
    n_tests++; if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'h99) begin n_fail++; $display("FAIL rm_fresh_data: got v=%b d=%h want v=1 d=99", rd_resp_valid, rd_resp_data); end
    n_tests++; if (mem[12] !== 8'h66 || mem[14] !== 8'h55) begin n_fail++; $display("FAIL rm_writes: got m12=%h m14=%h want 66/55", mem[12], mem[14]); end
    n_tests++; if (mem[13] !== 8'h00) begin n_fail++; $display("FAIL rm_reset_write: got %h want 00", mem[13]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_address = '0; wr_data = '0;
    rd_req_valid = 1'b0; rd_address = '0; rd_resp_ready = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_alternate();
    test_back_to_back();
    test_backpressure();
    test_read_then_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_mem_arbiter.md
Name: sp_mem_arbiter

Overview:
Front-end controller that sits directly upstream of the single-port memory and owns its write_en, data_in and address pins. It accepts independent valid/ready write and read request channels and serialises them onto the single port with round-robin arbitration. It tracks the memory's 1-cycle registered-address read latency and returns read data on a valid/ready response channel. A small response buffer absorbs backpressure.

Parameters:
DATAWIDTH, 8, data word width; must match the memory.
DATADEPTH, 1024, number of memory words.
ADDRESSWIDTH, $clog2(DATADEPTH), address width.
RESP_DEPTH, 2, response buffer entries; minimum 2.

Ports:
clk  input  1  single clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
wr_valid  input  1  write request present.
wr_ready  output  1  write accepted this cycle.
wr_address  input  ADDRESSWIDTH  write address.
wr_data  input  DATAWIDTH  write data.
rd_req_valid  input  1  read request present.
rd_req_ready  output  1  read request accepted this cycle.
rd_address  input  ADDRESSWIDTH  read address.
rd_resp_valid  output  1  read data available.
rd_resp_ready  input  1  consumer takes read data.
rd_resp_data  output  DATAWIDTH  read data, in request order.
mem_write_en  output  1  drives memory write_en.
mem_data_in  output  DATAWIDTH  drives memory data_in.
mem_address  output  ADDRESSWIDTH  drives memory address.
mem_data_out  input  DATAWIDTH  memory data_out.

Behaviour:
- Reset:
  - Outputs: wr_ready=0, rd_req_ready=0, rd_resp_valid=0, mem_write_en=0.
  - Internal state: response buffer empty, inflight=0, prefer_write=1.
  - mem_address and mem_data_in are don't-care during reset.
- One grant per cycle, combinational from the current cycle's inputs and state: GRANT_NONE, GRANT_WRITE or GRANT_READ.
- Write eligible: wr_valid.
- Read eligible: rd_req_valid AND (count + inflight - pop) < RESP_DEPTH, where pop = rd_resp_valid & rd_resp_ready.
- Arbitration:
  - Only one channel eligible: grant it.
  - Both eligible: grant write if prefer_write, else read.
  - prefer_write updates on every grant to the opposite of the channel just granted.
- GRANT_WRITE: wr_ready=1, mem_write_en=1, mem_address=wr_address, mem_data_in=wr_data. The memory is written at the same edge.
- GRANT_READ:
  - rd_req_ready=1, mem_write_en=0, mem_address=rd_address; inflight<=1 at the next edge.
  - Otherwise inflight<=0 at the next edge.
- GRANT_NONE: mem_write_en=0; mem_address holds its last value.
- Capture: in any cycle where inflight=1, mem_data_out is pushed into the response buffer at the end of that cycle.
  - Read latency from request acceptance to rd_resp_valid=1 is exactly 2 cycles when the buffer is empty.
  - A write granted in the capture cycle does not corrupt the capture; the memory's address register updates only at the edge.
- Response buffer: RESP_DEPTH-entry FIFO; rd_resp_valid = (count != 0); rd_resp_data = head entry.
  - Push and pop in the same cycle leave count unchanged.
  - The credit rule guarantees the buffer never overflows; overflow is an assertion failure.
- Throughput: with rd_resp_ready held high and only reads pending, one read is accepted every cycle.
- Ordering: writes and reads take effect in grant order. A read granted after a write to the same address returns the new data.
- Handshake rules:
  - wr_ready and rd_req_ready may depend combinationally on the valids and on rd_resp_ready.
  - Requesters must hold valid, address and data stable until their ready is seen.
  - rd_resp_valid, once high, stays high until popped.
- Reset mid-operation: any in-flight read is dropped and buffered responses are discarded. No memory write occurs in a cycle where reset=1.

Decomposition:
- Package sp_mem_pkg:
  - grant_t enum: GRANT_NONE, GRANT_WRITE, GRANT_READ.
  - RESP_DEPTH_MIN = 2.
- One sub-module, sp_mem_resp_fifo: register-based FIFO parameterised by DATAWIDTH/RESP_DEPTH, exporting count.
- Arbiter and credit logic stay in the top module.

Test Plan:
- Write 0xA5 to addr 3, then read addr 3 with rd_resp_ready=1 -> rd_resp_valid high exactly 2 cycles after rd_req_ready, data 0xA5.
- wr_valid and rd_req_valid held high together for 6 cycles with distinct addresses -> grants alternate W,R,W,R,W,R; first grant is W after reset.
- Back-to-back reads of addrs 0..7 preloaded 0x10..0x17, rd_resp_ready=1 -> rd_req_ready high every cycle; responses 0x10..0x17 in order on consecutive cycles.
- Reads streaming with rd_resp_ready=0 -> exactly 2 reads accepted, then rd_req_ready=0. Raising rd_resp_ready drains both in order, and reads resume with no loss or duplication.
- Read addr 5 (value 0x33) immediately followed by a write of 0x44 to addr 5 -> response 0x33. A following read of addr 5 returns 0x44.
- Assert reset one cycle after a read is granted -> rd_resp_valid stays 0, buffer empty, prefer_write=1. A fresh read after reset returns correct data.
